line_builder: RTL

- Sits directly downstream of the instruction controller and upstream of the data-cache BRAM.
- Consumes the controller's broadcast instruction word, register values and valid strobe.
- Executes the line-assembly opcodes SMA, LOADI, LOAD and SENDL against a private working line of 3*FMA_COUNT words.
- Commits finished lines to the data cache through a valid/ready write port.

---
 rtl/line_builder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/line_builder.sv
// Line assembly for the data cache: SMA/LOADI take effect next edge, LOAD fills FMA_COUNT words over FMA_COUNT busy cycles.
// Write port holds until wr_ready_in; a SENDL against a stalled write parks in WAIT. Option: LINE_BUILDER_CLEAR_ON_SEND_EN.
module line_builder #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int PRIVATE_REG_WIDTH = 16,
  parameter int DATA_WIDTH        = 16,
  parameter int FMA_COUNT         = 4,
  parameter int DATA_CACHE_DEPTH  = 4096,
  localparam int WORDS            = 3 * FMA_COUNT,
  localparam int ADDR_WIDTH       = $clog2(DATA_CACHE_DEPTH)
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [INSTRUCTION_WIDTH-1:0]  instr_in,
  input  logic [PRIVATE_REG_WIDTH-1:0]  reg_a_in,
  input  logic [PRIVATE_REG_WIDTH-1:0]  reg_b_in,
  input  logic [PRIVATE_REG_WIDTH-1:0]  reg_c_in,
  input  logic                          instr_valid_in,
  output logic                          busy_out,
  output logic [ADDR_WIDTH-1:0]         wr_addr_out,
  output logic [WORDS*DATA_WIDTH-1:0]   wr_data_out,
  output logic                          wr_valid_out,
  input  logic                          wr_ready_in,
  output logic                          err_out
);

  localparam int IDXW = $clog2(WORDS);
  localparam int CW   = (FMA_COUNT > 1) ? $clog2(FMA_COUNT) : 1;

  localparam logic [3:0] OP_SMA   = 4'b0110;
  localparam logic [3:0] OP_LOADI = 4'b0111;
  localparam logic [3:0] OP_SENDL = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b1010;

`ifdef LINE_BUILDER_CLEAR_ON_SEND_EN
  localparam bit CLEAR_ON_SEND = 1'b1;
`else
  localparam bit CLEAR_ON_SEND = 1'b0;
`endif

  // Field [0:3] is the MSB nibble, so the struct is declared op-first.
  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  ra;
    logic [15:0] imm;
    logic [3:0]  rb;
    logic [3:0]  rc;
  } instr_t;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WAIT} state_t;

  instr_t                             instr;
  state_t                             state_q, state_d;
  logic [WORDS-1:0][DATA_WIDTH-1:0]   line_q;
  logic [WORDS-1:0][DATA_WIDTH-1:0]   wr_line_q;
  logic [ADDR_WIDTH-1:0]              addr_reg, pend_addr, cap_addr;
  logic [DATA_WIDTH-1:0]              acc_q, diff_q;
  logic [1:0]                         slot_q;
  logic [CW-1:0]                      i_q;
  logic                               accept, err_set, capture;
  logic                               ra_word_ok, ra_slot_ok;
  logic [IDXW-1:0]                    ra_idx, fill_idx;
  logic                               unused_bits;

  assign instr       = instr_t'(instr_in);
  assign ra_word_ok  = 32'(instr.ra) < WORDS;
  assign ra_slot_ok  = instr.ra <= 4'd2;
  assign ra_idx      = IDXW'(instr.ra);
  assign fill_idx    = IDXW'(3 * 32'(i_q) + 32'(slot_q));
  assign wr_data_out = wr_line_q;
  assign unused_bits = ^{reg_a_in, reg_c_in, instr.rb, instr.rc, addr_reg};

  always_comb begin
    state_d  = state_q;
    err_set  = 1'b0;
    capture  = 1'b0;
    cap_addr = instr.imm[ADDR_WIDTH-1:0];
    accept   = instr_valid_in && !busy_out && (state_q == S_IDLE);
    if (instr_valid_in && busy_out) err_set = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (instr.op)
            OP_LOADI: if (!ra_word_ok) err_set = 1'b1;
            OP_LOAD:  if (ra_slot_ok) state_d = S_FILL; else err_set = 1'b1;
            OP_SENDL: if (!wr_valid_out || wr_ready_in) capture = 1'b1; else state_d = S_WAIT;
            default: ;
          endcase
        end
      end
      S_FILL: if (i_q == CW'(FMA_COUNT - 1)) state_d = S_IDLE;
      S_WAIT: begin
        // The parked SENDL commits on the edge that retires the stalled write.
        if (wr_ready_in) begin
          capture  = 1'b1;
          cap_addr = pend_addr;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      busy_out <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_out <= (state_d != S_IDLE);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      line_q       <= '0;
      wr_line_q    <= '0;
      wr_addr_out  <= '0;
      wr_valid_out <= 1'b0;
      err_out      <= 1'b0;
      addr_reg     <= '0;
      pend_addr    <= '0;
      acc_q        <= '0;
      diff_q       <= '0;
      slot_q       <= '0;
      i_q          <= '0;
    end else begin
      if (accept && instr.op == OP_SMA) addr_reg <= instr.imm[ADDR_WIDTH-1:0];
      if (accept && instr.op == OP_LOADI && ra_word_ok) line_q[ra_idx] <= DATA_WIDTH'(instr.imm);
      if (accept && instr.op == OP_LOAD && ra_slot_ok) begin
        slot_q <= instr.ra[1:0];
        diff_q <= DATA_WIDTH'(instr.imm);
        acc_q  <= DATA_WIDTH'(reg_b_in);
        i_q    <= '0;
      end
      if (accept && instr.op == OP_SENDL && state_d == S_WAIT) pend_addr <= instr.imm[ADDR_WIDTH-1:0];
      if (state_q == S_FILL) begin
        line_q[fill_idx] <= acc_q;
        acc_q            <= acc_q + diff_q;
        i_q              <= i_q + 1'b1;
      end
      if (capture) begin
        wr_line_q    <= line_q;
        wr_addr_out  <= cap_addr;
        wr_valid_out <= 1'b1;
        if (CLEAR_ON_SEND) line_q <= '0;
      end else if (wr_valid_out && wr_ready_in) begin
        wr_valid_out <= 1'b0;
      end
      if (err_set) err_out <= 1'b1;
    end
  end

endmodule
